// File: rtl/fifo_drain_ctrl.sv
// Drains a FIFO one word at a time and offers it to a byte consumer; drops and flags a byte the consumer never takes.
// Latency: 1 edge from FIFO_EMPTY low (ENABLE=1) to TX_DATA_VALID/FIFO_R_INC; at most one word per 3 cycles.
// Backpressure: TX_BUSY rising accepts the byte; no accept within TIMEOUT_CYCLES pulses TX_ERR. DRAIN_CNT_EN adds XFER_CNT.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
`ifdef DRAIN_CNT_EN
    ,
    parameter int CNT_WIDTH      = 16
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_R_INC,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    input  logic                  TX_BUSY,
    output logic                  TX_ERR
`ifdef DRAIN_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  XFER_CNT
`endif
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OFFER, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [TMO_W-1:0]        tmo_cnt, tmo_cnt_nxt;
    logic [DATA_WIDTH-1:0]   p_data_nxt;
    logic                    r_inc_nxt;
    logic                    vld_nxt;
    logic                    err_nxt;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            TX_P_DATA     <= '0;
            FIFO_R_INC    <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            TX_ERR        <= 1'b0;
        end else begin
            state         <= state_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            TX_P_DATA     <= p_data_nxt;
            FIFO_R_INC    <= r_inc_nxt;
            TX_DATA_VALID <= vld_nxt;
            TX_ERR        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        p_data_nxt  = TX_P_DATA;
        r_inc_nxt   = 1'b0;
        vld_nxt     = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (ENABLE && !FIFO_EMPTY) begin
                    p_data_nxt  = FIFO_RD_DATA;
                    r_inc_nxt   = 1'b1;
                    vld_nxt     = 1'b1;
                    tmo_cnt_nxt = '0;
                    state_nxt   = OFFER;
                end
            end
            OFFER: begin
                // Acceptance is checked first so it wins a tie with the timeout.
                if (TX_BUSY) begin
                    state_nxt = DRAIN;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    vld_nxt     = 1'b1;
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (!TX_BUSY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef DRAIN_CNT_EN
    logic accept;
    assign accept = (state == OFFER) && TX_BUSY;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            XFER_CNT <= '0;
        end else if (accept) begin
            XFER_CNT <= XFER_CNT + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed table of per-cycle vectors plus hand-written multi-cycle sequences for fifo_drain_ctrl.
module tb_fifo_drain_ctrl;

    logic       CLK = 1'b0;
    logic       tb_rst = 1'b0;
    logic       tb_en = 1'b0;
    logic       tb_empty = 1'b1;
    logic [7:0] tb_data = 8'h00;
    logic       tb_busy = 1'b0;
    logic       model_on = 1'b0;

    logic       FIFO_EMPTY;
    logic [7:0] FIFO_RD_DATA;
    logic       FIFO_R_INC;
    logic [7:0] TX_P_DATA;
    logic       TX_DATA_VALID;
    logic       TX_ERR;
`ifdef DRAIN_CNT_EN
    logic [15:0] XFER_CNT;
`endif

    // Small FIFO model used by the multi-byte sequence.
    logic [7:0] mem [0:7];
    logic [2:0] rd_ptr = 3'd0;
    logic [2:0] wr_ptr = 3'd0;

    assign FIFO_EMPTY   = model_on ? (rd_ptr == wr_ptr) : tb_empty;
    assign FIFO_RD_DATA = model_on ? mem[rd_ptr] : tb_data;

    always @(posedge CLK)
        if (model_on && FIFO_R_INC) rd_ptr <= rd_ptr + 3'd1;

    always #5 CLK = ~CLK;

    fifo_drain_ctrl dut (
        .CLK           (CLK),
        .RST           (tb_rst),
        .ENABLE        (tb_en),
        .FIFO_EMPTY    (FIFO_EMPTY),
        .FIFO_RD_DATA  (FIFO_RD_DATA),
        .FIFO_R_INC    (FIFO_R_INC),
        .TX_P_DATA     (TX_P_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .TX_BUSY       (tb_busy),
        .TX_ERR        (TX_ERR)
`ifdef DRAIN_CNT_EN
        ,
        .XFER_CNT      (XFER_CNT)
`endif
    );

    // Monitor: counts strobes per cycle, sampled on the falling edge.
    int         cyc = 0;
    int         n_inc = 0;
    int         n_err = 0;
    int         n_vld = 0;
    int         last_vld_cyc = 0;
    int         last_err_cyc = 0;
    int         inc_cyc [0:63];

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (FIFO_R_INC === 1'b1) begin
            if (n_inc < 64) inc_cyc[n_inc] = cyc;
            n_inc = n_inc + 1;
        end
        if (TX_ERR === 1'b1) begin
            n_err = n_err + 1;
            last_err_cyc = cyc;
        end
        if (TX_DATA_VALID === 1'b1) begin
            n_vld = n_vld + 1;
            last_vld_cyc = cyc;
        end
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic       empty;
        logic [7:0] data;
        logic       busy;
        logic       exp_inc;
        logic       exp_vld;
        logic [7:0] exp_pd;
        logic       exp_err;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [0:31];
    int   nv = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic en, input logic empty, input logic [7:0] data,
                       input logic busy, input logic inc, input logic vld, input logic [7:0] pd,
                       input logic err, input int cnt);
        vecs[nv] = '{rst, en, empty, data, busy, inc, vld, pd, err, cnt};
        nv = nv + 1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int b_inc, b_err, b_vld, n, mg;
`ifdef DRAIN_CNT_EN
    logic [15:0] cnt0;
`endif

    initial begin
        //   rst en emp data   busy | inc vld pd     err cnt
        add(0, 0, 1, 8'h00, 0,   0, 0, 8'h00, 0, 0);  // reset state
        add(1, 1, 0, 8'hA5, 0,   1, 1, 8'hA5, 0, 0);  // 1-edge fetch latency
        add(1, 1, 0, 8'hB6, 0,   0, 1, 8'hA5, 0, 0);
        add(1, 1, 0, 8'hB6, 0,   0, 1, 8'hA5, 0, 0);
        add(1, 1, 0, 8'hB6, 1,   0, 0, 8'hA5, 0, 1);  // accepted after 3 valid cycles
        add(1, 1, 0, 8'hB6, 1,   0, 0, 8'hA5, 0, 1);
        add(1, 1, 0, 8'hB6, 0,   0, 0, 8'hA5, 0, 1);
        add(1, 1, 0, 8'hB6, 0,   1, 1, 8'hB6, 0, 1);
        add(1, 1, 0, 8'hC7, 1,   0, 0, 8'hB6, 0, 2);  // busy on first OFFER cycle
        add(1, 0, 0, 8'hC7, 1,   0, 0, 8'hB6, 0, 2);  // ENABLE dropped in DRAIN
        add(1, 0, 0, 8'hC7, 0,   0, 0, 8'hB6, 0, 2);
        add(1, 0, 0, 8'hC7, 0,   0, 0, 8'hB6, 0, 2);  // no fetch while disabled
        add(1, 1, 1, 8'hC7, 0,   0, 0, 8'hB6, 0, 2);
        add(1, 1, 0, 8'h3C, 0,   1, 1, 8'h3C, 0, 2);
        add(0, 1, 0, 8'h3C, 0,   0, 0, 8'h00, 0, 0);  // reset mid-OFFER
        add(1, 0, 0, 8'h3C, 0,   0, 0, 8'h00, 0, 0);
        add(1, 1, 0, 8'h5A, 0,   1, 1, 8'h5A, 0, 0);
        add(1, 1, 0, 8'h5A, 1,   0, 0, 8'h5A, 0, 1);
        add(0, 1, 0, 8'h5A, 1,   0, 0, 8'h00, 0, 0);  // reset mid-DRAIN
        add(1, 1, 0, 8'h77, 1,   1, 1, 8'h77, 0, 0);
        add(1, 1, 0, 8'h77, 1,   0, 0, 8'h77, 0, 1);
        add(1, 1, 1, 8'h77, 0,   0, 0, 8'h77, 0, 1);
        add(1, 1, 1, 8'h77, 0,   0, 0, 8'h77, 0, 1);

        for (int i = 0; i < nv; i++) begin
            tb_rst   = vecs[i].rst;
            tb_en    = vecs[i].en;
            tb_empty = vecs[i].empty;
            tb_data  = vecs[i].data;
            tb_busy  = vecs[i].busy;
            tick();
            check($sformatf("row%0d {inc,vld,pd,err}", i),
                  {21'd0, FIFO_R_INC, TX_DATA_VALID, TX_P_DATA, TX_ERR},
                  {21'd0, vecs[i].exp_inc, vecs[i].exp_vld, vecs[i].exp_pd, vecs[i].exp_err});
`ifdef DRAIN_CNT_EN
            check($sformatf("row%0d xfer_cnt", i), {16'd0, XFER_CNT}, vecs[i].exp_cnt);
`endif
        end

        // Four queued bytes, consumer busy 10 cycles each.
        tb_busy = 1'b0;
        tb_en   = 1'b1;
        for (int k = 0; k < 4; k++) mem[rd_ptr + 3'(k)] = 8'(k + 1);
        b_inc = n_inc;
        b_err = n_err;
`ifdef DRAIN_CNT_EN
        cnt0 = XFER_CNT;
`endif
        model_on = 1'b1;
        wr_ptr   = rd_ptr + 3'd4;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (TX_DATA_VALID !== 1'b1 && n < 20) begin
                tick();
                n = n + 1;
            end
            check($sformatf("burst byte%0d offered in time", k), {31'd0, n < 20}, 32'd1);
            check($sformatf("burst byte%0d data", k), {24'd0, TX_P_DATA}, k + 1);
            tb_busy = 1'b1;
            repeat (10) tick();
            tb_busy = 1'b0;
        end
        repeat (4) tick();
        check("burst r_inc pulses", n_inc - b_inc, 4);
        mg = 1000;
        for (int k = b_inc + 1; k < n_inc && k < 64; k++)
            if (inc_cyc[k] - inc_cyc[k-1] < mg) mg = inc_cyc[k] - inc_cyc[k-1];
        check("burst r_inc spacing>=3", {31'd0, mg >= 3}, 32'd1);
        check("burst fifo drained", {31'd0, FIFO_EMPTY}, 32'd1);
        check("burst no err", n_err - b_err, 0);
`ifdef DRAIN_CNT_EN
        check("burst xfer_cnt", {16'd0, XFER_CNT}, {16'd0, cnt0 + 16'd4});
`endif
        model_on = 1'b0;
        tb_empty = 1'b1;
        tick();

        // Timeout: busy never rises.
        b_inc = n_inc;
        b_err = n_err;
        b_vld = n_vld;
`ifdef DRAIN_CNT_EN
        cnt0 = XFER_CNT;
`endif
        tb_empty = 1'b0;
        tb_data  = 8'h9E;
        tick();
        tb_empty = 1'b1;
        check("tmo data", {24'd0, TX_P_DATA}, 32'h9E);
        repeat (24) tick();
        check("tmo valid cycles", n_vld - b_vld, 16);
        check("tmo err pulses", n_err - b_err, 1);
        check("tmo err follows last valid", last_err_cyc - last_vld_cyc, 1);
        check("tmo single r_inc", n_inc - b_inc, 1);
        check("tmo back idle", {31'd0, TX_DATA_VALID}, 32'd0);
`ifdef DRAIN_CNT_EN
        check("tmo xfer_cnt unchanged", {16'd0, XFER_CNT}, {16'd0, cnt0});
`endif

        // Acceptance on the last allowed cycle beats the timeout.
        b_err = n_err;
        b_vld = n_vld;
`ifdef DRAIN_CNT_EN
        cnt0 = XFER_CNT;
`endif
        tb_empty = 1'b0;
        tb_data  = 8'h4D;
        tick();
        tb_empty = 1'b1;
        repeat (15) tick();
        check("tie still valid", {31'd0, TX_DATA_VALID}, 32'd1);
        tb_busy = 1'b1;
        tick();
        check("tie accepted {vld,err}", {30'd0, TX_DATA_VALID, TX_ERR}, 32'd0);
        tb_busy = 1'b0;
        repeat (3) tick();
        check("tie valid cycles", n_vld - b_vld, 16);
        check("tie no err", n_err - b_err, 0);
`ifdef DRAIN_CNT_EN
        check("tie xfer_cnt", {16'd0, XFER_CNT}, {16'd0, cnt0 + 16'd1});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
